// File: rtl/result_writeback_arbiter_pkg.sv
// Shared processor definitions: execution unit encodings and datapath width defaults.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package result_writeback_arbiter_pkg;

    // Execution unit identifiers, also used as the writeback source tag.
    typedef enum logic [1:0] {
        UNIT_ADD    = 2'b00,
        UNIT_MULT   = 2'b01,
        UNIT_MULADD = 2'b10
    } unit_t;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    // Request/grant vectors are indexed by unit: bit0 ADD, bit1 MULT, bit2 MULADD.
    localparam int UNIT_CNT = 3;

endpackage

// File: rtl/result_writeback_arbiter_rr.sv
// Three-way round-robin arbiter: one-hot grant to the first requester after the last granted unit.
// Latency: purely combinational.
// Backpressure: none; the caller masks the grant when the consumer cannot accept.
// Ports: req (bit0 ADD, bit1 MULT, bit2 MULADD), ptr (last granted unit), grant (one-hot, zero if no req).
module rr_arbiter_3
    import result_writeback_arbiter_pkg::*;
(
    input  logic [UNIT_CNT-1:0] req,
    input  unit_t               ptr,
    output logic [UNIT_CNT-1:0] grant
);

    // Search order starts at the unit after ptr and wraps ADD -> MULT -> MULADD -> ADD.
    always_comb begin
        grant = '0;
        case (ptr)
            UNIT_ADD: begin
                if      (req[1]) grant = 3'b010;
                else if (req[2]) grant = 3'b100;
                else if (req[0]) grant = 3'b001;
            end
            UNIT_MULT: begin
                if      (req[2]) grant = 3'b100;
                else if (req[0]) grant = 3'b001;
                else if (req[1]) grant = 3'b010;
            end
            default: begin
                if      (req[0]) grant = 3'b001;
                else if (req[1]) grant = 3'b010;
                else if (req[2]) grant = 3'b100;
            end
        endcase
    end

endmodule

// File: rtl/result_writeback_arbiter.sv
// Merges ADD/MULT/MULADD results into one register-file writeback port with round-robin fairness.
// Latency: one cycle from unit accept to wb_*; one result per cycle sustained.
// Backpressure: unit readys drop to 0 while the held wb entry is stalled by wb_ready=0.
// Ports: clk/rst (async active-high); per unit valid/ready/data/dest; wb_valid/wb_ready/wb_data/wb_dest/wb_src.
module result_writeback_arbiter
    import result_writeback_arbiter_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              add_valid,
    output logic              add_ready,
    input  logic [DATA_W-1:0] add_data,
    input  logic [ADDR_W-1:0] add_dest,
    input  logic              mult_valid,
    output logic              mult_ready,
    input  logic [DATA_W-1:0] mult_data,
    input  logic [ADDR_W-1:0] mult_dest,
    input  logic              muladd_valid,
    output logic              muladd_ready,
    input  logic [DATA_W-1:0] muladd_data,
    input  logic [ADDR_W-1:0] muladd_dest,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [DATA_W-1:0] wb_data,
    output logic [ADDR_W-1:0] wb_dest,
    output logic [1:0]        wb_src
);

    logic [UNIT_CNT-1:0] req;
    logic [UNIT_CNT-1:0] grant;
    logic [UNIT_CNT-1:0] ready;
    unit_t               ptr;
    unit_t               src_q;
    unit_t               sel_unit;
    logic [DATA_W-1:0]   sel_data;
    logic [ADDR_W-1:0]   sel_dest;
    logic                free;
    logic                accept;
    logic                stall;
    logic [15:0]         perf_stall;

    assign req = {muladd_valid, mult_valid, add_valid};

    rr_arbiter_3 u_rr (
        .req   (req),
        .ptr   (ptr),
        .grant (grant)
    );

    // Output slot can take a new entry if empty or being drained this cycle.
    assign free   = !wb_valid || wb_ready;
    // rst gating keeps readys low during reset even though the slot reads as free.
    assign ready  = grant & {UNIT_CNT{free && !rst}};
    assign accept = |ready;
    assign stall  = |(req & ~ready);

    assign add_ready    = ready[0];
    assign mult_ready   = ready[1];
    assign muladd_ready = ready[2];
    assign wb_src       = src_q;

    always_comb begin
        sel_unit = UNIT_ADD;
        sel_data = add_data;
        sel_dest = add_dest;
        if (grant[1]) begin
            sel_unit = UNIT_MULT;
            sel_data = mult_data;
            sel_dest = mult_dest;
        end else if (grant[2]) begin
            sel_unit = UNIT_MULADD;
            sel_data = muladd_data;
            sel_dest = muladd_dest;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid   <= 1'b0;
            wb_data    <= '0;
            wb_dest    <= '0;
            src_q      <= UNIT_ADD;
            ptr        <= UNIT_MULADD;  // so ADD is searched first after reset
            perf_stall <= 16'd0;
        end else begin
            if (accept) begin
                wb_valid <= 1'b1;
                wb_data  <= sel_data;
                wb_dest  <= sel_dest;
                src_q    <= sel_unit;
                ptr      <= sel_unit;
            end else if (wb_ready) begin
                wb_valid <= 1'b0;
            end
            if (stall && (perf_stall != 16'hFFFF)) begin
                perf_stall <= perf_stall + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_result_writeback_arbiter.sv
module tb_result_writeback_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        add_valid, mult_valid, muladd_valid;
    logic        add_ready, mult_ready, muladd_ready;
    logic [31:0] add_data, mult_data, muladd_data;
    logic [4:0]  add_dest, mult_dest, muladd_dest;
    logic        wb_valid, wb_ready;
    logic [31:0] wb_data;
    logic [4:0]  wb_dest;
    logic [1:0]  wb_src;

    int checks = 0;
    int failures = 0;

    wire [2:0] rdy = {muladd_ready, mult_ready, add_ready};

    always #5 clk = ~clk;

    result_writeback_arbiter dut (
        .clk(clk), .rst(rst),
        .add_valid(add_valid), .add_ready(add_ready), .add_data(add_data), .add_dest(add_dest),
        .mult_valid(mult_valid), .mult_ready(mult_ready), .mult_data(mult_data), .mult_dest(mult_dest),
        .muladd_valid(muladd_valid), .muladd_ready(muladd_ready), .muladd_data(muladd_data),
        .muladd_dest(muladd_dest),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_dest(wb_dest), .wb_src(wb_src)
    );

    task automatic test_reset();
        rst = 1'b1;
        add_valid = 1'b1; mult_valid = 1'b1; muladd_valid = 1'b1; wb_ready = 1'b1;
        add_data = 32'h0; mult_data = 32'h0; muladd_data = 32'h0;
        add_dest = 5'd0; mult_dest = 5'd0; muladd_dest = 5'd0;
        #3;
        checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", wb_valid); end
        checks++; if (wb_data !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", wb_data); end
        checks++; if (wb_dest !== 5'd0) begin failures++; $display("FAIL reset_dest got=%0d exp=0", wb_dest); end
        checks++; if (wb_src !== 2'b00) begin failures++; $display("FAIL reset_src got=%b exp=00", wb_src); end
        checks++; if (rdy !== 3'b000) begin failures++; $display("FAIL reset_ready got=%b exp=000", rdy); end
        @(posedge clk); @(posedge clk); #1;
        checks++; if (dut.perf_stall !== 16'd0) begin failures++; $display("FAIL reset_stall got=%0d exp=0", dut.perf_stall); end
        add_valid = 1'b0; mult_valid = 1'b0; muladd_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single_add();
        add_valid = 1'b1; add_data = 32'h0000_0011; add_dest = 5'd3; wb_ready = 1'b1;
        #1;
        checks++; if (rdy !== 3'b001) begin failures++; $display("FAIL add_ready got=%b exp=001", rdy); end
        @(posedge clk); #1;
        checks++; if (wb_valid !== 1'b1) begin failures++; $display("FAIL add_wb_valid got=%b exp=1", wb_valid); end
        checks++; if (wb_data !== 32'h11) begin failures++; $display("FAIL add_wb_data got=%h exp=11", wb_data); end
        checks++; if (wb_dest !== 5'd3) begin failures++; $display("FAIL add_wb_dest got=%0d exp=3", wb_dest); end
        checks++; if (wb_src !== 2'b00) begin failures++; $display("FAIL add_wb_src got=%b exp=00", wb_src); end
        @(negedge clk);
        add_valid = 1'b0;
        #1;
        checks++; if (rdy !== 3'b000) begin failures++; $display("FAIL idle_ready got=%b exp=000", rdy); end
        @(posedge clk); #1;
        checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL drain_empty got=%b exp=0", wb_valid); end
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        logic [2:0]  exp_g [4];
        logic [1:0]  exp_s [4];
        logic [31:0] exp_d [4];
        exp_g = '{3'b001, 3'b010, 3'b100, 3'b001};
        exp_s = '{2'b00, 2'b01, 2'b10, 2'b00};
        exp_d = '{32'hA0, 32'hB0, 32'hC0, 32'hA0};
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        add_valid = 1'b1; add_data = 32'hA0; add_dest = 5'd1;
        mult_valid = 1'b1; mult_data = 32'hB0; mult_dest = 5'd2;
        muladd_valid = 1'b1; muladd_data = 32'hC0; muladd_dest = 5'd4;
        wb_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (rdy !== exp_g[i]) begin failures++; $display("FAIL rr_grant%0d got=%b exp=%b", i, rdy, exp_g[i]); end
            @(posedge clk); #1;
            checks++; if (wb_src !== exp_s[i]) begin failures++; $display("FAIL rr_src%0d got=%b exp=%b", i, wb_src, exp_s[i]); end
            checks++; if (wb_data !== exp_d[i]) begin failures++; $display("FAIL rr_data%0d got=%h exp=%h", i, wb_data, exp_d[i]); end
            @(negedge clk);
        end
        add_valid = 1'b0; mult_valid = 1'b0; muladd_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL rr_drain got=%b exp=0", wb_valid); end
        @(negedge clk);
    endtask

    task automatic test_stall();
        int s0;
        muladd_valid = 1'b1; muladd_data = 32'hDEAD_BEEF; muladd_dest = 5'd7; wb_ready = 1'b0;
        #1;
        checks++; if (rdy !== 3'b100) begin failures++; $display("FAIL stall_load_ready got=%b exp=100", rdy); end
        @(posedge clk); #1;
        checks++; if (wb_data !== 32'hDEAD_BEEF) begin failures++; $display("FAIL stall_load_data got=%h exp=deadbeef", wb_data); end
        checks++; if (wb_src !== 2'b10) begin failures++; $display("FAIL stall_load_src got=%b exp=10", wb_src); end
        s0 = int'(dut.perf_stall);
        @(negedge clk);
        muladd_data = 32'h0000_1234; muladd_dest = 5'd8;
        for (int k = 1; k <= 4; k++) begin
            #1;
            checks++; if (rdy !== 3'b000) begin failures++; $display("FAIL stall_ready%0d got=%b exp=000", k, rdy); end
            @(posedge clk); #1;
            checks++; if ({wb_valid, wb_data, wb_dest, wb_src} !== {1'b1, 32'hDEAD_BEEF, 5'd7, 2'b10}) begin
                failures++; $display("FAIL stall_hold%0d got=%b/%h/%0d/%b exp=1/deadbeef/7/10", k, wb_valid, wb_data, wb_dest, wb_src);
            end
            checks++; if (int'(dut.perf_stall) != s0 + k) begin failures++; $display("FAIL stall_count%0d got=%0d exp=%0d", k, dut.perf_stall, s0 + k); end
            @(negedge clk);
        end
        wb_ready = 1'b1;
        #1;
        checks++; if (rdy !== 3'b100) begin failures++; $display("FAIL stall_release_ready got=%b exp=100", rdy); end
        @(posedge clk); #1;
        checks++; if (wb_data !== 32'h1234 || wb_dest !== 5'd8) begin failures++; $display("FAIL stall_next got=%h/%0d exp=1234/8", wb_data, wb_dest); end
        checks++; if (int'(dut.perf_stall) != s0 + 4) begin failures++; $display("FAIL stall_count_end got=%0d exp=%0d", dut.perf_stall, s0 + 4); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        muladd_valid = 1'b0;
        mult_valid = 1'b1; mult_data = 32'h0000_CAFE; mult_dest = 5'd9; wb_ready = 1'b1;
        #1;
        checks++; if (rdy !== 3'b010) begin failures++; $display("FAIL b2b_ready got=%b exp=010", rdy); end
        @(posedge clk); #1;
        checks++; if (wb_valid !== 1'b1 || wb_src !== 2'b01) begin failures++; $display("FAIL b2b_out got=%b/%b exp=1/01", wb_valid, wb_src); end
        checks++; if (wb_data !== 32'hCAFE || wb_dest !== 5'd9) begin failures++; $display("FAIL b2b_data got=%h/%0d exp=cafe/9", wb_data, wb_dest); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        mult_valid = 1'b0; wb_ready = 1'b0;
        @(posedge clk); #1;
        checks++; if (wb_valid !== 1'b1 || wb_data !== 32'hCAFE) begin failures++; $display("FAIL idle_hold got=%b/%h exp=1/cafe", wb_valid, wb_data); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (wb_valid !== 1'b0 || wb_data !== 32'h0 || wb_src !== 2'b00) begin
            failures++; $display("FAIL async_reset got=%b/%h/%b exp=0/0/00", wb_valid, wb_data, wb_src);
        end
        add_valid = 1'b1; add_data = 32'h55; add_dest = 5'd5;
        mult_valid = 1'b1; mult_data = 32'h66; mult_dest = 5'd6;
        wb_ready = 1'b1;
        #1;
        checks++; if (rdy !== 3'b000) begin failures++; $display("FAIL reset_hold_ready got=%b exp=000", rdy); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (rdy !== 3'b001) begin failures++; $display("FAIL post_reset_grant got=%b exp=001", rdy); end
        @(posedge clk); #1;
        checks++; if (wb_src !== 2'b00 || wb_data !== 32'h55) begin failures++; $display("FAIL post_reset_out got=%b/%h exp=00/55", wb_src, wb_data); end
        @(negedge clk); #1;
        checks++; if (rdy !== 3'b010) begin failures++; $display("FAIL post_reset_next got=%b exp=010", rdy); end
        @(posedge clk); #1;
        checks++; if (wb_src !== 2'b01 || wb_data !== 32'h66) begin failures++; $display("FAIL post_reset_mult got=%b/%h exp=01/66", wb_src, wb_data); end
        @(negedge clk);
        add_valid = 1'b0; mult_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_round_robin();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/result_writeback_arbiter.md
RESULT_WRITEBACK_ARBITER -- requirements
Module: result_writeback_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, width of result data.
REQ-002 Parameter ADDR_W, default 5, width of destination register address.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 add_valid / mult_valid / muladd_valid  input  1 each  unit result available.
REQ-006 add_ready / mult_ready / muladd_ready  output  1 each  result accepted this cycle.
REQ-007 add_data / mult_data / muladd_data  input  DATA_W each  unit result value.
REQ-008 add_dest / mult_dest / muladd_dest  input  ADDR_W each  destination register.
REQ-009 wb_valid  output  1  writeback entry valid.
REQ-010 wb_ready  input  1  register file accepts writeback.
REQ-011 wb_data  output  DATA_W  writeback value.
REQ-012 wb_dest  output  ADDR_W  writeback register address.
REQ-013 wb_src  output  2  originating unit: ADD 2'b00, MULT 2'b01, MULADD 2'b10.

Function
REQ-014 Transfer on a unit port or wb port occurs when valid and ready are both high at a rising edge.
REQ-015 Block holds one output register (wb_valid/wb_data/wb_dest/wb_src); output register "free" = !wb_valid or (wb_valid and wb_ready).
REQ-016 When free, exactly one requesting unit receives ready=1 that cycle, chosen by round-robin; all others ready=0.
REQ-017 When not free, all unit ready outputs are 0.
REQ-018 Unit ready is combinational from current valids, grant pointer and wb_valid/wb_ready; ready never depends on that unit's own data.
REQ-019 Round-robin order ADD -> MULT -> MULADD -> ADD; search starts at the unit after the last granted unit.
REQ-020 Grant pointer updates only on an accepted unit transfer; unchanged otherwise.
REQ-021 Latency: accepted unit result appears on wb_* at the next rising edge (1 cycle).
REQ-022 Simultaneous wb drain and unit accept in the same cycle: output register reloads with new entry, wb_valid stays 1 (full throughput, one result per cycle).
REQ-023 wb drain with no requesting unit: wb_valid falls to 0 next cycle.
REQ-024 While wb_valid=1 and wb_ready=0, wb_data/wb_dest/wb_src hold stable.
REQ-025 No unit valid: no grant, pointer and output register unchanged except drain per REQ-023.
REQ-026 Single requesting unit is granted regardless of pointer position (no idle bubbles).
REQ-027 Counter perf_stall (16-bit, internal, readable in simulation) increments each cycle any unit valid=1 with its ready=0; saturates at 16'hFFFF.

Reset
REQ-028 rst asserted: wb_valid=0, wb_data=0, wb_dest=0, wb_src=2'b00, grant pointer = MULADD (so ADD has first priority), perf_stall=0, immediately and asynchronously.
REQ-029 Reset mid-transfer discards the held wb entry; no partial writeback after deassertion.
REQ-030 Unit ready outputs are 0 while rst is high.

Structure
REQ-031 Unit encodings ADD/MULT/MULADD (2-bit) and DATA_W/ADDR_W defaults live in the shared processor package, common with the operand routing logic.
REQ-032 Round-robin selection is a sub-module rr_arbiter_3 (3 requests, pointer in, one-hot grant out); output register and counter stay in the top module.

Verification
REQ-033 Reset then ADD valid data=32'h0000_0011 dest=3, wb_ready=1 -> add_ready=1 cycle 0, wb_valid=1 wb_data=32'h11 wb_dest=3 wb_src=00 cycle 1.
REQ-034 All three valid continuously, wb_ready=1 -> grants ADD, MULT, MULADD, ADD in consecutive cycles, wb_src 00,01,10,00.
REQ-035 MULADD valid data=32'hDEAD_BEEF, wb_ready=0 for 4 cycles -> wb_* held stable, all readys 0, perf_stall increments per waiting unit cycle; wb_ready=1 drains then next grant.
REQ-036 Output full, wb_ready=1 and MULT valid same cycle -> wb_valid stays 1, next cycle wb_src=01, no bubble.
REQ-037 rst pulsed while wb_valid=1 -> wb_valid=0 asynchronously, after release ADD wins first over simultaneous MULT.
